cache_store_buffer: RTL and testbench

- Store-side counterpart of the data-cache request exception check.
- Accepts CPU store requests (address, byte/half/word type, data) and checks alignment.
- Misaligned stores are rejected with a registered ADEM exception code.
- Aligned stores are lane-shifted, given a byte strobe, queued in a small FIFO, and drained to the memory/cache write port over a valid/ready handshake. Sits between the EX/MEM store path and the dcache write interface; also flags read-after-write hazards for loads.

---
 rtl/cache_store_buffer_pkg.sv | 36 +++
 rtl/store_fifo.sv | 72 +++++++
 rtl/cache_store_buffer.sv | 105 ++++++++++
 tb/tb_cache_store_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_store_buffer_pkg.sv
// Shared definitions for the data-cache store path: access types, exception codes, entry layout.
package cache_store_buffer_pkg;

   // Exception code width and the address-error-on-store code
   localparam int unsigned EXC_W = 7;
   localparam logic [EXC_W-1:0] EXP_ADEM = 7'h08;

   // Access masks shared with the load-side exception check
   localparam logic [3:0] ACC_BYTE = 4'b0001;
   localparam logic [3:0] ACC_HALF = 4'b0011;
   localparam logic [3:0] ACC_WORD = 4'b1111;

   // One queued store; addr is the MSB field, wstrb the LSB field
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } st_entry_t;

   localparam int unsigned ENTRY_W = $bits(st_entry_t);

   // Unknown access masks behave as a word access
   function automatic logic [3:0] norm_type(input logic [3:0] t);
      if (t == ACC_BYTE || t == ACC_HALF) return t;
      return ACC_WORD;
   endfunction

   function automatic logic is_misaligned(input logic [3:0] t, input logic [1:0] lo);
      logic [3:0] nt;
      nt = norm_type(t);
      if (nt == ACC_BYTE) return 1'b0;
      if (nt == ACC_HALF) return lo[0];
      return lo != 2'b00;
   endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers, flush, and a per-slot view for snooping.
module store_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 68
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               push,
   input  logic [W-1:0]       wdata,
   input  logic               pop,
   input  logic               flush,
   output logic [W-1:0]       rdata,
   output logic               full,
   output logic               empty,
   output logic [DEPTH-1:0]   slot_valid,
   output logic [DEPTH*W-1:0] slots
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = IW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
   logic [W-1:0]  mem_q [DEPTH];
   logic [IW-1:0] slot_off [DEPTH];
   logic          do_push, do_pop;

   assign full    = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = wr_ptr_q - rd_ptr_q;
   assign rdata   = mem_q[rd_ptr_q[IW-1:0]];

   // Next pointers; flush wins over push and pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; no reset needed since reads are qualified by empty
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q[IW-1:0]] <= wdata;
   end

   // A slot is live when its distance from the head is below the occupancy
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_off[i]        = IW'(i) - rd_ptr_q[IW-1:0];
         slot_valid[i]      = {1'b0, slot_off[i]} < count;
         slots[i*W +: W]    = mem_q[i];
      end
   end

endmodule

// File: rtl/cache_store_buffer.sv
// Store buffer: alignment check, exception report, lane shifting, FIFO drain and RAW snoop.
module cache_store_buffer
   import cache_store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             st_valid,
   output logic             st_ready,
   input  logic [AW-1:0]    st_addr,
   input  logic [3:0]       st_type,
   input  logic [DW-1:0]    st_wdata,
   output logic             exp_valid,
   output logic [EXC_W-1:0] exception,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic [AW-1:0]    ld_addr,
   output logic             ld_hazard,
   input  logic             flush,
   output logic             empty
);

   logic                       full, accept, misaligned, push;
   logic [1:0]                 off;
   st_entry_t                  in_entry, head;
   logic [ENTRY_W-1:0]         head_raw;
   logic [DEPTH-1:0]           slot_valid;
   logic [DEPTH*ENTRY_W-1:0]   slots;
   logic                       exp_valid_q;
   logic [EXC_W-1:0]           exception_q;
   logic                       unused_bits;

   assign st_ready   = !full;
   assign accept     = st_valid && st_ready;
   assign off        = st_addr[1:0];
   assign misaligned = is_misaligned(st_type, off);
   assign push       = accept && !misaligned;

   // Word-align the address and move data/strobes onto their byte lanes
   always_comb begin
      in_entry       = '0;
      in_entry.addr  = {st_addr[31:2], 2'b00};
      in_entry.wstrb = norm_type(st_type) << off;
      in_entry.wdata = st_wdata << {off, 3'b000};
   end

   store_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push       (push),
      .wdata      (in_entry),
      .pop        (mem_ready),
      .flush      (flush),
      .rdata      (head_raw),
      .full       (full),
      .empty      (empty),
      .slot_valid (slot_valid),
      .slots      (slots)
   );

   assign head      = st_entry_t'(head_raw);
   assign mem_valid = !empty;
   assign mem_addr  = head.addr;
   assign mem_wdata = head.wdata;
   assign mem_wstrb = head.wstrb;

   // One-cycle report of the outcome of every accepted store, flushed or not
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exp_valid_q <= 1'b0;
         exception_q <= '0;
      end else begin
         exp_valid_q <= accept;
         exception_q <= (accept && misaligned) ? EXP_ADEM : '0;
      end
   end

   assign exp_valid = exp_valid_q;
   assign exception = exception_q;

   // Load hazard: any live entry hitting the load's word with some byte enabled
   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_valid[i] &&
             slots[i*ENTRY_W + 38 +: 30] == ld_addr[31:2] &&
             slots[i*ENTRY_W +: 4] != 4'b0000) begin
            ld_hazard = 1'b1;
         end
      end
   end

   // Word data of the slot view and the load byte offset do not affect the snoop
   assign unused_bits = ^{slots, ld_addr[1:0]};

endmodule

// File: tb/tb_cache_store_buffer.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs a queue model.
module tb_cache_store_buffer;
   import cache_store_buffer_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        st_valid, st_ready;
   logic [31:0] st_addr, st_wdata;
   logic [3:0]  st_type;
   logic        exp_valid;
   logic [6:0]  exception;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] ld_addr;
   logic        ld_hazard, flush, empty;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cache_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_addr   (st_addr),
      .st_type   (st_type),
      .st_wdata  (st_wdata),
      .exp_valid (exp_valid),
      .exception (exception),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .ld_addr   (ld_addr),
      .ld_hazard (ld_hazard),
      .flush     (flush),
      .empty     (empty)
   );

   // Reference model: a queue of pending stores plus the pending exception report
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } ment_t;

   ment_t      mq[$];
   logic       m_expv;
   logic [6:0] m_exc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] t,
                        input logic [31:0] d, input logic mr, input logic [31:0] la,
                        input logic fl);
      @(negedge clk);
      st_valid  = v;
      st_addr   = a;
      st_type   = t;
      st_wdata  = d;
      mem_ready = mr;
      ld_addr   = la;
      flush     = fl;
      #1;
   endtask

   task automatic model_check();
      logic haz;
      haz = 1'b0;
      foreach (mq[i]) if (mq[i].a[31:2] == ld_addr[31:2] && mq[i].s != 0) haz = 1'b1;
      chk("st_ready", st_ready, mq.size() < DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("mem_valid", mem_valid, mq.size() != 0);
      chk("exp_valid", exp_valid, m_expv);
      chk("exception", exception, m_exc);
      chk("ld_hazard", ld_hazard, haz);
      if (mq.size() != 0) begin
         chk("mem_addr", mem_addr, mq[0].a);
         chk("mem_wdata", mem_wdata, mq[0].d);
         chk("mem_wstrb", mem_wstrb, mq[0].s);
      end
   endtask

   // Applies the store rules to the inputs sampled at the clock edge
   task automatic model_update();
      logic       acc, mis;
      int         nbytes, off;
      ment_t      e;
      acc    = st_valid && (mq.size() < DEPTH);
      off    = int'(st_addr[1:0]);
      nbytes = (st_type == ACC_BYTE) ? 1 : (st_type == ACC_HALF) ? 2 : 4;
      mis    = (off % nbytes) != 0;
      e.a    = st_addr & 32'hFFFF_FFFC;
      e.d    = st_wdata << (8 * off);
      e.s    = 4'b0000;
      for (int b = 0; b < 4; b++) if (b >= off && b < off + nbytes) e.s[b] = 1'b1;
      m_expv = acc;
      m_exc  = (acc && mis) ? EXP_ADEM : 7'd0;
      if (flush) begin
         mq.delete();
      end else begin
         if (mem_ready && mq.size() != 0) void'(mq.pop_front());
         if (acc && !mis) mq.push_back(e);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] a, input logic [3:0] t,
                       input logic [31:0] d, input logic mr, input logic [31:0] la,
                       input logic fl);
      drive(v, a, t, d, mr, la, fl);
      model_check();
      @(posedge clk);
      model_update();
   endtask

   typedef struct {
      logic        v;
      logic [31:0] a;
      logic [3:0]  t;
      logic [31:0] d;
      logic        mr;
      logic [31:0] la;
      logic        e_expv;
      logic [6:0]  e_exc;
      logic        e_mv;
      logic [31:0] e_maddr;
      logic [31:0] e_mdata;
      logic [3:0]  e_strb;
      logic        e_rdy;
      logic        e_haz;
   } vec_t;

   vec_t vt [10];

   initial begin
      logic [31:0] ra, rl;
      logic [3:0]  rt;
      int          sel;

      vt[0] = '{1'b1, 32'h1000_0004, ACC_WORD, 32'hDEAD_BEEF, 1'b1, 32'h0,
                1'b0, 7'd0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0};
      vt[1] = '{1'b0, 32'h0, ACC_WORD, 32'h0, 1'b1, 32'h0,
                1'b1, 7'd0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0};
      vt[2] = '{1'b1, 32'h2003, ACC_HALF, 32'h1234, 1'b1, 32'h0,
                1'b0, 7'd0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0};
      vt[3] = '{1'b1, 32'h2003, ACC_BYTE, 32'hAB, 1'b0, 32'h0,
                1'b1, EXP_ADEM, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0};
      vt[4] = '{1'b0, 32'h0, ACC_WORD, 32'h0, 1'b0, 32'h2000,
                1'b1, 7'd0, 1'b1, 32'h2000, 32'hAB00_0000, 4'h8, 1'b1, 1'b1};
      vt[5] = '{1'b1, 32'h3002, ACC_HALF, 32'h5566, 1'b0, 32'h3000,
                1'b0, 7'd0, 1'b1, 32'h2000, 32'hAB00_0000, 4'h8, 1'b1, 1'b0};
      vt[6] = '{1'b0, 32'h0, ACC_WORD, 32'h0, 1'b1, 32'h3000,
                1'b1, 7'd0, 1'b1, 32'h2000, 32'hAB00_0000, 4'h8, 1'b1, 1'b1};
      vt[7] = '{1'b0, 32'h0, ACC_WORD, 32'h0, 1'b0, 32'h3004,
                1'b0, 7'd0, 1'b1, 32'h3000, 32'h5566_0000, 4'hC, 1'b1, 1'b0};
      vt[8] = '{1'b0, 32'h0, ACC_WORD, 32'h0, 1'b1, 32'h3000,
                1'b0, 7'd0, 1'b1, 32'h3000, 32'h5566_0000, 4'hC, 1'b1, 1'b1};
      vt[9] = '{1'b0, 32'h0, ACC_WORD, 32'h0, 1'b0, 32'h3000,
                1'b0, 7'd0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0};

      rstn = 1'b0; st_valid = 1'b0; st_addr = '0; st_type = ACC_WORD; st_wdata = '0;
      mem_ready = 1'b0; ld_addr = '0; flush = 1'b0;
      m_expv = 1'b0; m_exc = '0;
      #12;
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_exp_valid", exp_valid, 1'b0);
      chk("rst_exception", exception, 7'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_st_ready", st_ready, 1'b1);
      chk("rst_ld_hazard", ld_hazard, 1'b0);
      @(negedge clk);
      rstn = 1'b1;

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         drive(vt[i].v, vt[i].a, vt[i].t, vt[i].d, vt[i].mr, vt[i].la, 1'b0);
         model_check();
         chk("vec_exp_valid", exp_valid, vt[i].e_expv);
         chk("vec_exception", exception, vt[i].e_exc);
         chk("vec_mem_valid", mem_valid, vt[i].e_mv);
         chk("vec_st_ready", st_ready, vt[i].e_rdy);
         chk("vec_ld_hazard", ld_hazard, vt[i].e_haz);
         if (vt[i].e_mv) begin
            chk("vec_mem_addr", mem_addr, vt[i].e_maddr);
            chk("vec_mem_wdata", mem_wdata, vt[i].e_mdata);
            chk("vec_mem_wstrb", mem_wstrb, vt[i].e_strb);
         end
         @(posedge clk);
         model_update();
      end

      // Fill with memory stalled, refuse a fifth store, then release one entry at a time
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'h100 + 32'(4 * i), ACC_WORD, 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h110, ACC_WORD, 32'hBAD0_0000, 1'b0, 32'h0, 1'b0);
      chk("full_st_ready", st_ready, 1'b0);
      chk("full_head_stable", mem_addr, 32'h100);
      step(1'b1, 32'h114, ACC_WORD, 32'hBAD1_0000, 1'b1, 32'h0, 1'b0);
      step(1'b0, 32'h0, ACC_WORD, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("after_pop_head", mem_addr, 32'h104);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, ACC_WORD, 32'h0, 1'b1, 32'h0, 1'b0);

      // Back-to-back stores with continuous drain, wrapping the pointers
      for (int i = 0; i < 10; i++)
         step(1'b1, 32'h500 + 32'(4 * i), ACC_WORD, 32'hC000_0000 + 32'(i), 1'b1, 32'h0, 1'b0);
      step(1'b0, 32'h0, ACC_WORD, 32'h0, 1'b1, 32'h0, 1'b0);

      // Flush with three pending and a store in the same cycle
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h600 + 32'(4 * i), ACC_WORD, 32'h11 * 32'(i + 1), 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h700, ACC_WORD, 32'h7777_7777, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, ACC_WORD, 32'h0, 1'b0, 32'h700, 1'b0);
      chk("flush_empty", empty, 1'b1);
      chk("flush_mem_valid", mem_valid, 1'b0);
      chk("flush_exp_valid", exp_valid, 1'b1);
      chk("flush_no_hazard", ld_hazard, 1'b0);
      model_check();
      @(posedge clk);
      model_update();

      // Asynchronous reset while draining
      step(1'b1, 32'h800, ACC_WORD, 32'h1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h804, ACC_WORD, 32'h2, 1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, ACC_WORD, 32'h0, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("rst_mid_mem_valid", mem_valid, 1'b0);
      chk("rst_mid_st_ready", st_ready, 1'b1);
      chk("rst_mid_empty", empty, 1'b1);
      mq.delete();
      m_expv = 1'b0;
      m_exc  = '0;
      @(negedge clk);
      rstn = 1'b1;

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 2));
         rt  = (sel == 0) ? ACC_BYTE : (sel == 1) ? ACC_HALF : ACC_WORD;
         ra  = 32'h4000 + 32'($urandom_range(0, 15));
         rl  = 32'h4000 + 32'($urandom_range(0, 15));
         step(1'($urandom_range(0, 1)), ra, rt, $urandom, 1'($urandom_range(0, 2) != 0), rl,
              1'($urandom_range(0, 31) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
